// File: rtl/byte_serializer_pkg.sv
// Shared types and field layout for the byte serializer: frame geometry,
// FSM state encoding and bit offsets of the packed input/output buses.
package byte_serializer_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam int IN_W          = 9;
  localparam int IN_VALID_BIT  = 8;
  localparam int IN_DATA_LSB   = 0;

  localparam int OUT_W         = 10;
  localparam int OUT_READY_BIT = 9;
  localparam int OUT_LINE_BIT  = 8;
  localparam int OUT_DROP_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/byte_serializer_if.sv
// Byte-offer / serial-status bundle between the upstream counter stage and
// the serializer. Handshake: a byte transfers on a posedge where valid and
// ready are both 1; ready depends only on registered state, never on valid.
interface byte_serializer_if;
  import byte_serializer_pkg::*;

  logic [IN_W-1:0]  __in0;
  logic [OUT_W-1:0] __out0;

  modport master (output __in0, input  __out0);
  modport slave  (input  __in0, output __out0);
endinterface

// File: rtl/byte_serializer_bit_tick_gen.sv
// Bit-time divider: pulses tick_o on the last cycle of every BIT_CYCLES-long
// bit-time while enabled; the clear forces the count back to zero.
module bit_tick_gen #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Serializes accepted bytes as start / 8 data (LSB first) / even parity / stop
// on a registered idle-high line, counting bytes refused while busy.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  byte_serializer_if.slave   bus,
  output state_e             dbg_state_o
);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   line_q, line_d;
  logic [7:0]             drop_q, drop_d;
  logic [2:0]             idx_q, idx_d;

  logic                   valid, ready, accept, tick;
  logic [DATA_BITS-1:0]   data;

  assign valid  = bus.__in0[IN_VALID_BIT];
  assign data   = bus.__in0[IN_DATA_LSB +: DATA_BITS];
  assign ready  = (state_q == ST_IDLE);
  assign accept = valid && ready;

  bit_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    drop_d   = drop_q;

    if (valid && !ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      ST_IDLE: if (accept) begin
        shift_d  = data;
        parity_d = ^data;
        idx_d    = '0;
        state_d  = ST_START;
      end
      ST_START:  if (tick) state_d = ST_DATA;
      ST_DATA: if (tick) begin
        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Line is registered from the next state so it lines up with that state.
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = parity_d;
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      line_q   <= 1'b1;
      drop_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      line_q   <= line_d;
      drop_q   <= drop_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    bus.__out0                                = '0;
    bus.__out0[OUT_READY_BIT]                 = ready;
    bus.__out0[OUT_LINE_BIT]                  = line_q;
    bus.__out0[OUT_DROP_LSB +: 8]             = drop_q;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer with BIT_CYCLES=1 and BIT_CYCLES=3 instances.
module tb_byte_serializer;
  import byte_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_serializer_if if1 ();
  byte_serializer_if if3 ();
  state_e st1, st3;

  byte_serializer #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .dbg_state_o(st1)
  );
  byte_serializer #(.BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .dbg_state_o(st3)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [0:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 1) if1.__in0 = {v, d};
    else          if3.__in0 = {v, d};
  endtask

  function automatic logic [9:0] out_of(input int sel);
    return (sel == 1) ? if1.__out0 : if3.__out0;
  endfunction

  function automatic logic model_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  // Offer one byte from IDLE and follow the whole frame cycle by cycle.
  task automatic frame(input int sel, input int bc, input logic [7:0] d,
                       input string tag, output logic [10:0] cap);
    int n;
    logic [9:0] o;
    logic [0:0] e;
    cap = '0;
    for (int k = 0; k < FRAME_BITS; k++)
      repeat (bc) exp_q.push_back(model_bit(d, k));
    n = exp_q.size();
    drive(sel, 1'b1, d);
    step();
    drive(sel, 1'b0, 8'h00);
    for (int c = 0; c < n; c++) begin
      if (c > 0) step();
      o = out_of(sel);
      e = exp_q.pop_front();
      chk({tag, "_line"}, 32'(o[OUT_LINE_BIT]), 32'(e));
      chk({tag, "_busy"}, 32'(o[OUT_READY_BIT]), 32'd0);
      cap[c / bc] = o[OUT_LINE_BIT];
    end
    step();
    o = out_of(sel);
    chk({tag, "_ready_back"}, 32'(o[OUT_READY_BIT]), 32'd1);
    chk({tag, "_idle_line"}, 32'(o[OUT_LINE_BIT]), 32'd1);
  endtask

  initial begin
    logic [10:0] cap;
    logic [9:0]  o;
    int          rdy_cnt;

    rst = 1'b0;
    drive(1, 1'b0, 8'h00);
    drive(3, 1'b0, 8'h00);
    step();
    step();
    chk("rst_out1", 32'(out_of(1)), 32'h300);
    chk("rst_out3", 32'(out_of(3)), 32'h300);
    chk("rst_state1", 32'(st1), 32'(ST_IDLE));
    rst = 1'b1;
    step();
    chk("idle_out1", 32'(out_of(1)), 32'h300);

    frame(1, 1, 8'hA5, "a5", cap);
    chk("a5_seq", 32'(cap), 32'(11'b10101001010));
    chk("a5_drop", 32'(out_of(1) & 10'h0FF), 32'h0);

    frame(1, 1, 8'h00, "d00", cap);
    chk("d00_parity", 32'(cap[9]), 32'd0);
    frame(1, 1, 8'h07, "d07", cap);
    chk("d07_parity", 32'(cap[9]), 32'd1);

    frame(3, 3, 8'h01, "bc3", cap);
    chk("bc3_seq", 32'(cap), 32'(11'b11000000010));

    // Offer 0xFF and keep valid high, then reset on the 5th DATA cycle.
    drive(1, 1'b1, 8'hFF);
    step();
    repeat (5) step();
    o = out_of(1);
    chk("mid_drop", 32'(o[7:0]), 32'd5);
    chk("mid_state", 32'(st1), 32'(ST_DATA));
    rst = 1'b0;
    step();
    chk("abort_out", 32'(out_of(1)), 32'h300);
    chk("abort_state", 32'(st1), 32'(ST_IDLE));
    rst = 1'b1;
    drive(1, 1'b0, 8'h00);
    step();
    chk("abort_hold", 32'(out_of(1)), 32'h300);
    frame(1, 1, 8'h3C, "post_rst", cap);
    chk("post_rst_seq", 32'(cap), 32'(11'b10001111000));

    // Reset coincident with an offered byte in IDLE.
    drive(1, 1'b1, 8'h5A);
    rst = 1'b0;
    step();
    chk("rst_accept_out", 32'(out_of(1)), 32'h300);
    chk("rst_accept_state", 32'(st1), 32'(ST_IDLE));
    rst = 1'b1;
    drive(1, 1'b0, 8'h00);
    step();
    chk("rst_accept_after", 32'(out_of(1)), 32'h300);
    chk("rst_accept_state2", 32'(st1), 32'(ST_IDLE));

    // Free-running upstream counter offering a byte every cycle.
    rdy_cnt = 0;
    for (int i = 0; i < 360; i++) begin
      o = out_of(1);
      if (o[OUT_READY_BIT]) rdy_cnt++;
      drive(1, 1'b1, 8'(i));
      step();
      if (i == 11) chk("cnt_drop_frame1", 32'(out_of(1) & 10'h0FF), 32'd11);
      if (i == 12) begin
        chk("cnt_drop_accept", 32'(out_of(1) & 10'h0FF), 32'd11);
        chk("cnt_state_accept", 32'(st1), 32'(ST_START));
      end
    end
    drive(1, 1'b0, 8'h00);
    chk("cnt_accepts", 32'(rdy_cnt), 32'd30);
    chk("cnt_drop_sat", 32'(out_of(1) & 10'h0FF), 32'hFF);
    drive(1, 1'b1, 8'h00);
    repeat (12) step();
    drive(1, 1'b0, 8'h00);
    chk("cnt_drop_hold", 32'(out_of(1) & 10'h0FF), 32'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter BIT_CYCLES, default 1, meaning clock cycles per serial bit-time (legal range 1..255).
REQ-002 clk  input  1  rising-edge system clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-low: rst==0 sampled at posedge clk resets the block.
REQ-004 __in0  input  9  {valid[8], data[7:0]}: byte offered by the upstream 8-bit counter stage; valid=1 marks data as meaningful this cycle.
REQ-005 __out0  output  10  {ready[9], line[8], drop_cnt[7:0]}: ready = byte accepted this cycle if valid; line = serial output, idle high; drop_cnt = saturating count of refused bytes.

Function
REQ-006 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-007 ready SHALL be 1 exactly when state==IDLE, decoded from registered state with no combinational path from __in0.
REQ-008 Accept: valid=1 and ready=1 at a posedge SHALL latch data into the shift register and move to START.
REQ-009 line SHALL be registered: 1 in IDLE and STOP, 0 in START, shift-register bit 0 in DATA, parity bit in PARITY.
REQ-010 Each of START, PARITY, STOP SHALL last exactly BIT_CYCLES cycles; DATA SHALL last 8*BIT_CYCLES cycles.
REQ-011 Data SHALL go out LSB first, shifting right once at the end of each DATA bit-time.
REQ-012 Parity SHALL be even: XOR of the 8 latched data bits, computed at accept.
REQ-013 Transitions: IDLE->START on accept; START->DATA, DATA->PARITY after the 8th bit, PARITY->STOP, STOP->IDLE, each on the last cycle of its bit-time.
REQ-014 First start-bit cycle on line SHALL be the cycle after accept; IDLE re-entry SHALL occur 11*BIT_CYCLES cycles after accept, giving a minimum accept spacing of 11*BIT_CYCLES+1 cycles.
REQ-015 valid=1 with ready=0 SHALL increment drop_cnt by 1, saturating at 8'hFF; valid=1 with ready=1 SHALL NOT increment it.
REQ-016 data SHALL be ignored whenever valid=0 or ready=0; a byte is never partially latched.
REQ-017 Bit-time counter SHALL count 0..BIT_CYCLES-1 and wrap; it SHALL be held at 0 in IDLE.

Reset
REQ-018 rst==0 at a posedge SHALL set state=IDLE, line=1, ready=1, drop_cnt=0, shift register=0, parity=0, bit counter=0, bit index=0.
REQ-019 rst==0 mid-frame SHALL abort the frame; line SHALL read 1 the next cycle with no partial stop bit and no increment of drop_cnt.
REQ-020 rst==0 overrides a simultaneous accept; the offered byte is discarded and not counted as dropped.
REQ-021 No register SHALL change except at posedge clk; there SHALL be no asynchronous reset path.

Structure
REQ-022 A shared package SHALL hold the state enum, FRAME_BITS=11, DATA_BITS=8, and the field offsets of __in0 and __out0.
REQ-023 One sub-module, bit_tick_gen, SHALL generate the end-of-bit-time tick from BIT_CYCLES, with an enable and a synchronous clear.
REQ-024 Target implementation size is 120-400 lines of RTL in total.

Verification
REQ-025 BIT_CYCLES=1, single valid with data=8'hA5 in IDLE -> line from next cycle: 0,1,0,1,0,0,1,0,1,0,1; ready returns 1 on cycle 12 after accept.
REQ-026 BIT_CYCLES=3, data=8'h01 -> start 3 cycles low, d0 3 cycles high, d1..d7 21 cycles low, parity 3 cycles high, stop 3 cycles high; 33 cycles total.
REQ-027 Upstream counter driving valid=1 every cycle, BIT_CYCLES=1 -> accepts every 12th cycle, 11 drops per frame; drop_cnt reaches 8'hFF and holds.
REQ-028 Reset (rst=0) on 5th DATA cycle of 8'hFF -> line=1, ready=1, drop_cnt=0 on the following cycle; next accepted byte serializes correctly.
REQ-029 rst=0 coincident with valid=1 in IDLE -> state stays IDLE, line stays 1, drop_cnt stays 0.
REQ-030 data=8'h00 -> parity bit 0; data=8'h07 -> parity bit 1.
